// File: rtl/hazard_forward_controller_pkg.sv
// Shared types and constants for the decode-stage hazard/forwarding controller.
package hazard_pkg;

    typedef enum logic [1:0] {
        FWD_REG = 2'd0,
        FWD_EX  = 2'd1,
        FWD_MEM = 2'd2
    } fwd_sel_t;

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        LOAD_STALL = 2'd1,
        MEM_WAIT   = 2'd2
    } hz_state_t;

    localparam logic [4:0] XZR = 5'd31;

    typedef struct packed {
        logic [4:0] rd;
        logic       reg_write;
        logic       mem_to_reg;
    } stage_t;

    localparam stage_t STAGE_EMPTY = '{rd: 5'd0, reg_write: 1'b0, mem_to_reg: 1'b0};

    // A load still in EX cannot supply data yet, so only a MEM producer can serve that source
    function automatic fwd_sel_t pick_sel(input logic ex_hit, input logic ex_load, input logic mem_hit);
        if (ex_hit && !ex_load) begin
            return FWD_EX;
        end else if (mem_hit) begin
            return FWD_MEM;
        end else begin
            return FWD_REG;
        end
    endfunction

endpackage

// File: rtl/hazard_forward_controller_if.sv
// Decode-side bundle between the pipeline and the hazard/forwarding controller.
interface hazard_forward_controller_if #(
    parameter int CNT_W = 32
);
    logic [4:0]       Rn_Decode;
    logic [4:0]       Src2_Decode;
    logic             useRn_Decode;
    logic             useSrc2_Decode;
    logic             useWr_Decode;
    logic [4:0]       Rd_Decode;
    logic             RegWrite_Decode;
    logic             MemToReg_Decode;
    logic             BrTaken_Decode;
    logic             memBusy;
    logic [1:0]       forwardingSelA;
    logic [1:0]       forwardingSelB;
    logic [1:0]       forwardingSelWr;
    logic             pcWrite_en;
    logic             fetchRegWrite_en;
    logic             decodeBubble;
    logic             pipeFreeze;
    logic             flushFetch;
    logic [CNT_W-1:0] stallCount;
    logic [CNT_W-1:0] flushCount;

    modport master (
        output Rn_Decode, Src2_Decode, useRn_Decode, useSrc2_Decode, useWr_Decode,
               Rd_Decode, RegWrite_Decode, MemToReg_Decode, BrTaken_Decode, memBusy,
        input  forwardingSelA, forwardingSelB, forwardingSelWr, pcWrite_en,
               fetchRegWrite_en, decodeBubble, pipeFreeze, flushFetch, stallCount, flushCount
    );

    modport slave (
        input  Rn_Decode, Src2_Decode, useRn_Decode, useSrc2_Decode, useWr_Decode,
               Rd_Decode, RegWrite_Decode, MemToReg_Decode, BrTaken_Decode, memBusy,
        output forwardingSelA, forwardingSelB, forwardingSelWr, pcWrite_en,
               fetchRegWrite_en, decodeBubble, pipeFreeze, flushFetch, stallCount, flushCount
    );
endinterface

// File: rtl/hazard_forward_controller_fwd_compare.sv
// Per-source comparison against the EX/MEM destination shadow: mux select plus load-use hit.
module fwd_compare
    import hazard_pkg::*;
(
    input  logic [4:0] src,
    input  logic       src_used,
    input  stage_t     ex_stage,
    input  stage_t     mem_stage,
    output fwd_sel_t   sel,
    output logic       load_use
);
    logic ex_hit_s;
    logic mem_hit_s;

    // XZR reads as zero, so it never matches a producer
    always_comb begin
        sel       = FWD_REG;
        load_use  = 1'b0;
        ex_hit_s  = ex_stage.reg_write && (ex_stage.rd == src) && (src != XZR);
        mem_hit_s = mem_stage.reg_write && (mem_stage.rd == src) && (src != XZR);
        if (src_used) begin
            sel      = pick_sel(ex_hit_s, ex_stage.mem_to_reg, mem_hit_s);
            load_use = ex_hit_s && ex_stage.mem_to_reg;
        end else begin
            sel      = FWD_REG;
            load_use = 1'b0;
        end
    end
endmodule

// File: rtl/hazard_forward_controller.sv
// Hazard and forwarding controller for the 5-stage pipeline: forwarding selects,
// load-use bubbles, memory-wait freeze, branch fetch flush and saturating counters.
module hazard_forward_controller
    import hazard_pkg::*;
#(
    parameter bit BR_DELAY_SLOT = 1'b1,
    parameter int CNT_W         = 32
) (
    input logic                        clk,
    input logic                        reset,
    hazard_forward_controller_if.slave hz
);
    localparam logic [CNT_W-1:0] CNT_MAX_C = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE_C = {{(CNT_W-1){1'b0}}, 1'b1};

    stage_t           ex_r, mem_r, dec_s;
    hz_state_t        state_r, next_state_s;
    fwd_sel_t         sel_a_s, sel_b_s, sel_wr_s;
    logic             lu_a_s, lu_b_s, lu_wr_s, load_use_s;
    logic             pc_en_s, fetch_en_s, bubble_s, freeze_s, flush_s;
    logic [CNT_W-1:0] stall_cnt_r, flush_cnt_r;

    assign dec_s = '{rd: hz.Rd_Decode, reg_write: hz.RegWrite_Decode, mem_to_reg: hz.MemToReg_Decode};

    fwd_compare u_cmp_a (.src(hz.Rn_Decode), .src_used(hz.useRn_Decode), .ex_stage(ex_r),
                         .mem_stage(mem_r), .sel(sel_a_s), .load_use(lu_a_s));
    fwd_compare u_cmp_b (.src(hz.Src2_Decode), .src_used(hz.useSrc2_Decode), .ex_stage(ex_r),
                         .mem_stage(mem_r), .sel(sel_b_s), .load_use(lu_b_s));
    fwd_compare u_cmp_wr (.src(hz.Src2_Decode), .src_used(hz.useWr_Decode), .ex_stage(ex_r),
                          .mem_stage(mem_r), .sel(sel_wr_s), .load_use(lu_wr_s));

    assign load_use_s = lu_a_s | lu_b_s | lu_wr_s;

    // Next state: memory wait outranks load-use; a bubble just entered EX so a stall never repeats
    always_comb begin
        next_state_s = RUN;
        case (state_r)
            LOAD_STALL: begin
                if (hz.memBusy) next_state_s = MEM_WAIT;
                else            next_state_s = RUN;
            end
            RUN, MEM_WAIT: begin
                if (hz.memBusy)       next_state_s = MEM_WAIT;
                else if (load_use_s)  next_state_s = LOAD_STALL;
                else                  next_state_s = RUN;
            end
            default: next_state_s = RUN;
        endcase
    end

    // Pipeline controls follow this cycle's classification; held benign while reset is asserted
    always_comb begin
        pc_en_s    = 1'b1;
        fetch_en_s = 1'b1;
        bubble_s   = 1'b0;
        freeze_s   = 1'b0;
        flush_s    = 1'b0;
        if (reset) begin
            flush_s = !BR_DELAY_SLOT && hz.BrTaken_Decode && !load_use_s && !hz.memBusy;
            case (next_state_s)
                MEM_WAIT: begin
                    pc_en_s    = 1'b0;
                    fetch_en_s = 1'b0;
                    freeze_s   = 1'b1;
                end
                LOAD_STALL: begin
                    pc_en_s    = 1'b0;
                    fetch_en_s = 1'b0;
                    bubble_s   = 1'b1;
                end
                default: begin
                    pc_en_s    = 1'b1;
                    fetch_en_s = 1'b1;
                end
            endcase
        end else begin
            flush_s = 1'b0;
        end
    end

    // State register and EX/MEM destination shadow
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= RUN;
            ex_r    <= STAGE_EMPTY;
            mem_r   <= STAGE_EMPTY;
        end else begin
            state_r <= next_state_s;
            case (next_state_s)
                RUN: begin
                    ex_r  <= dec_s;
                    mem_r <= ex_r;
                end
                LOAD_STALL: begin
                    ex_r  <= STAGE_EMPTY;
                    mem_r <= ex_r;
                end
                default: begin
                    ex_r  <= ex_r;
                    mem_r <= mem_r;
                end
            endcase
        end
    end

    // Saturating stall and flush counters
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt_r <= {CNT_W{1'b0}};
            flush_cnt_r <= {CNT_W{1'b0}};
        end else begin
            if ((load_use_s || hz.memBusy) && (stall_cnt_r != CNT_MAX_C)) begin
                stall_cnt_r <= stall_cnt_r + CNT_ONE_C;
            end
            if (flush_s && (flush_cnt_r != CNT_MAX_C)) begin
                flush_cnt_r <= flush_cnt_r + CNT_ONE_C;
            end
        end
    end

    assign hz.forwardingSelA   = sel_a_s;
    assign hz.forwardingSelB   = sel_b_s;
    assign hz.forwardingSelWr  = sel_wr_s;
    assign hz.pcWrite_en       = pc_en_s;
    assign hz.fetchRegWrite_en = fetch_en_s;
    assign hz.decodeBubble     = bubble_s;
    assign hz.pipeFreeze       = freeze_s;
    assign hz.flushFetch       = flush_s;
    assign hz.stallCount       = stall_cnt_r;
    assign hz.flushCount       = flush_cnt_r;
endmodule

// File: tb/tb_hazard_forward_controller.sv
// Bench for hazard_forward_controller: directed scenarios plus random traffic against an
// instruction-level pipeline model. dut0 flushes on branches (32-bit counters), dut1 has a delay slot (4-bit counters).
module tb_hazard_forward_controller;
    import hazard_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    hazard_forward_controller_if #(.CNT_W(32)) if0 ();
    hazard_forward_controller_if #(.CNT_W(4))  if1 ();

    hazard_forward_controller #(.BR_DELAY_SLOT(1'b0), .CNT_W(32)) dut0 (.clk(clk), .reset(reset), .hz(if0));
    hazard_forward_controller #(.BR_DELAY_SLOT(1'b1), .CNT_W(4))  dut1 (.clk(clk), .reset(reset), .hz(if1));

    logic [4:0] in_rn, in_src2, in_rd;
    logic       in_urn, in_us2, in_uwr, in_rw, in_ld, in_br, in_busy;

    assign if0.Rn_Decode = in_rn;        assign if1.Rn_Decode = in_rn;
    assign if0.Src2_Decode = in_src2;    assign if1.Src2_Decode = in_src2;
    assign if0.useRn_Decode = in_urn;    assign if1.useRn_Decode = in_urn;
    assign if0.useSrc2_Decode = in_us2;  assign if1.useSrc2_Decode = in_us2;
    assign if0.useWr_Decode = in_uwr;    assign if1.useWr_Decode = in_uwr;
    assign if0.Rd_Decode = in_rd;        assign if1.Rd_Decode = in_rd;
    assign if0.RegWrite_Decode = in_rw;  assign if1.RegWrite_Decode = in_rw;
    assign if0.MemToReg_Decode = in_ld;  assign if1.MemToReg_Decode = in_ld;
    assign if0.BrTaken_Decode = in_br;   assign if1.BrTaken_Decode = in_br;
    assign if0.memBusy = in_busy;        assign if1.memBusy = in_busy;

    // Reference model: the two instructions ahead of decode (index 0 = EX, 1 = MEM)
    typedef struct {
        logic [4:0] rd;
        logic       wr;
        logic       ld;
    } slot_t;
    slot_t pipe [2];

    logic [1:0]  e_a, e_b, e_w;
    logic        e_lu, e_pc, e_bub, e_frz, e_fl0;
    logic [31:0] m_st0, m_fl0;
    logic [3:0]  m_st1;
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [4:0]  regs [4];

    function automatic logic [1:0] fwd_of(input logic [4:0] s, input logic used);
        if (!used || s == 5'd31) return 2'd0;
        if (pipe[0].wr && pipe[0].rd == s && !pipe[0].ld) return 2'd1;
        if (pipe[1].wr && pipe[1].rd == s) return 2'd2;
        return 2'd0;
    endfunction

    function automatic logic waits_on_load(input logic [4:0] s, input logic used);
        return used && s != 5'd31 && pipe[0].wr && pipe[0].ld && pipe[0].rd == s;
    endfunction

    task automatic compute_exp();
        if (!reset) begin
            e_a = 2'd0; e_b = 2'd0; e_w = 2'd0;
            e_lu = 1'b0; e_pc = 1'b1; e_bub = 1'b0; e_frz = 1'b0; e_fl0 = 1'b0;
        end else begin
            e_a   = fwd_of(in_rn, in_urn);
            e_b   = fwd_of(in_src2, in_us2);
            e_w   = fwd_of(in_src2, in_uwr);
            e_lu  = waits_on_load(in_rn, in_urn) || waits_on_load(in_src2, in_us2) || waits_on_load(in_src2, in_uwr);
            e_frz = in_busy;
            e_pc  = !(in_busy || e_lu);
            e_bub = e_lu && !in_busy;
            e_fl0 = in_br && !e_lu && !in_busy;
        end
    endtask

    task automatic model_clear();
        pipe[0] = '{rd: 5'd0, wr: 1'b0, ld: 1'b0};
        pipe[1] = '{rd: 5'd0, wr: 1'b0, ld: 1'b0};
        m_st0 = 32'd0; m_st1 = 4'd0; m_fl0 = 32'd0;
    endtask

    task automatic settle();
        #1;
        compute_exp();
    endtask

    // Apply the upcoming clock edge to the model, then wait for the next falling edge
    task automatic advance();
        compute_exp();
        if (!reset) begin
            model_clear();
        end else begin
            if (in_busy || e_lu) begin
                if (m_st0 != 32'hFFFF_FFFF) m_st0 = m_st0 + 32'd1;
                if (m_st1 != 4'hF) m_st1 = m_st1 + 4'd1;
            end
            if (e_fl0 && m_fl0 != 32'hFFFF_FFFF) m_fl0 = m_fl0 + 32'd1;
            if (!in_busy) begin
                pipe[1] = pipe[0];
                if (e_lu) pipe[0] = '{rd: 5'd0, wr: 1'b0, ld: 1'b0};
                else      pipe[0] = '{rd: in_rd, wr: in_rw, ld: in_ld};
            end
        end
        @(negedge clk);
    endtask

    task automatic set_dec(input logic [4:0] a, input logic [4:0] b, input logic ua, input logic ub,
                           input logic uw, input logic [4:0] d, input logic w, input logic l,
                           input logic brt, input logic bsy);
        in_rn = a; in_src2 = b; in_urn = ua; in_us2 = ub; in_uwr = uw;
        in_rd = d; in_rw = w; in_ld = l; in_br = brt; in_busy = bsy;
    endtask

    task automatic nops(input int n);
        for (int i = 0; i < n; i++) begin
            set_dec(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
            advance();
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        model_clear();
        set_dec(5'd1, 5'd1, 1'b1, 1'b1, 1'b1, 5'd1, 1'b1, 1'b1, 1'b1, 1'b1);
        @(negedge clk);
        settle();
        n_tests++; if (if0.pipeFreeze !== 1'b0) begin n_fail++; $display("FAIL rst_freeze got=%b exp=0", if0.pipeFreeze); end
        n_tests++; if (if0.pcWrite_en !== 1'b1 || if0.fetchRegWrite_en !== 1'b1) begin n_fail++; $display("FAIL rst_enables got=%b%b exp=11", if0.pcWrite_en, if0.fetchRegWrite_en); end
        n_tests++; if (if0.flushFetch !== 1'b0 || if0.decodeBubble !== 1'b0) begin n_fail++; $display("FAIL rst_flush_bubble got=%b%b exp=00", if0.flushFetch, if0.decodeBubble); end
        n_tests++; if ({if0.forwardingSelA, if0.forwardingSelB, if0.forwardingSelWr} !== 6'd0) begin n_fail++; $display("FAIL rst_sels got=%b exp=0", {if0.forwardingSelA, if0.forwardingSelB, if0.forwardingSelWr}); end
        n_tests++; if (if0.stallCount !== 32'd0 || if0.flushCount !== 32'd0) begin n_fail++; $display("FAIL rst_counts got=%0d/%0d exp=0/0", if0.stallCount, if0.flushCount); end
        advance();
        reset = 1'b1;
        nops(2);
    endtask

    task automatic test_alu_forward();
        set_dec(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0);
        advance();
        set_dec(5'd1, 5'd3, 1'b1, 1'b1, 1'b0, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0);
        settle();
        n_tests++; if (if0.forwardingSelA !== 2'd1 || if0.pcWrite_en !== 1'b1) begin n_fail++; $display("FAIL alu_ex_selA got=%0d pc=%b exp=1 pc=1", if0.forwardingSelA, if0.pcWrite_en); end
        n_tests++; if (if0.forwardingSelB !== 2'd0) begin n_fail++; $display("FAIL alu_ex_selB got=%0d exp=0", if0.forwardingSelB); end
        advance();
        set_dec(5'd2, 5'd1, 1'b1, 1'b1, 1'b0, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0);
        settle();
        n_tests++; if (if0.forwardingSelA !== 2'd1 || if0.forwardingSelB !== 2'd2) begin n_fail++; $display("FAIL alu_mem_sels got=%0d/%0d exp=1/2", if0.forwardingSelA, if0.forwardingSelB); end
        advance();
        nops(2);
    endtask

    task automatic test_load_use();
        set_dec(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0);
        advance();
        set_dec(5'd7, 5'd5, 1'b1, 1'b1, 1'b0, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0);
        settle();
        n_tests++; if (if0.pcWrite_en !== 1'b0 || if0.decodeBubble !== 1'b1 || if0.fetchRegWrite_en !== 1'b0) begin n_fail++; $display("FAIL lu_stall pc=%b bub=%b fe=%b exp=0/1/0", if0.pcWrite_en, if0.decodeBubble, if0.fetchRegWrite_en); end
        n_tests++; if (if0.stallCount !== 32'd0) begin n_fail++; $display("FAIL lu_cnt_before got=%0d exp=0", if0.stallCount); end
        advance();
        settle();
        n_tests++; if (if0.forwardingSelB !== 2'd2 || if0.pcWrite_en !== 1'b1 || if0.decodeBubble !== 1'b0) begin n_fail++; $display("FAIL lu_resume selB=%0d pc=%b bub=%b exp=2/1/0", if0.forwardingSelB, if0.pcWrite_en, if0.decodeBubble); end
        n_tests++; if (if0.stallCount !== 32'd1) begin n_fail++; $display("FAIL lu_cnt_after got=%0d exp=1", if0.stallCount); end
        advance();
        nops(2);
    endtask

    task automatic test_cbz_flush();
        set_dec(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0);
        advance();
        set_dec(5'd0, 5'd5, 1'b0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        settle();
        n_tests++; if (if0.flushFetch !== 1'b0 || if0.decodeBubble !== 1'b1) begin n_fail++; $display("FAIL cbz_stall flush=%b bub=%b exp=0/1", if0.flushFetch, if0.decodeBubble); end
        advance();
        settle();
        n_tests++; if (if0.forwardingSelWr !== 2'd2 || if0.flushFetch !== 1'b1) begin n_fail++; $display("FAIL cbz_resume selWr=%0d flush=%b exp=2/1", if0.forwardingSelWr, if0.flushFetch); end
        n_tests++; if (if1.flushFetch !== 1'b0) begin n_fail++; $display("FAIL cbz_delay_slot flush=%b exp=0", if1.flushFetch); end
        advance();
        nops(1);
        settle();
        n_tests++; if (if0.flushCount !== 32'd1 || if1.flushCount !== 4'd0) begin n_fail++; $display("FAIL cbz_flush_count got=%0d/%0d exp=1/0", if0.flushCount, if1.flushCount); end
        nops(1);
    endtask

    task automatic test_xzr();
        set_dec(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd31, 1'b1, 1'b1, 1'b0, 1'b0);
        advance();
        set_dec(5'd31, 5'd31, 1'b1, 1'b1, 1'b1, 5'd31, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            settle();
            n_tests++; if ({if0.forwardingSelA, if0.forwardingSelB, if0.forwardingSelWr} !== 6'd0 || if0.pcWrite_en !== 1'b1) begin n_fail++; $display("FAIL xzr_c%0d sels=%b pc=%b exp=0/1", i, {if0.forwardingSelA, if0.forwardingSelB, if0.forwardingSelWr}, if0.pcWrite_en); end
            advance();
        end
        nops(2);
    endtask

    task automatic test_mem_wait();
        logic [31:0] st_before;
        set_dec(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0);
        advance();
        st_before = m_st0;
        set_dec(5'd5, 5'd2, 1'b1, 1'b1, 1'b0, 5'd6, 1'b1, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            settle();
            n_tests++; if (if0.pipeFreeze !== 1'b1 || if0.pcWrite_en !== 1'b0 || if0.decodeBubble !== 1'b0) begin n_fail++; $display("FAIL mw_freeze%0d frz=%b pc=%b bub=%b exp=1/0/0", i, if0.pipeFreeze, if0.pcWrite_en, if0.decodeBubble); end
            advance();
        end
        in_busy = 1'b0;
        settle();
        n_tests++; if (if0.pipeFreeze !== 1'b0 || if0.decodeBubble !== 1'b1) begin n_fail++; $display("FAIL mw_then_stall frz=%b bub=%b exp=0/1", if0.pipeFreeze, if0.decodeBubble); end
        advance();
        settle();
        n_tests++; if (if0.forwardingSelA !== 2'd2 || if0.pcWrite_en !== 1'b1) begin n_fail++; $display("FAIL mw_resume selA=%0d pc=%b exp=2/1", if0.forwardingSelA, if0.pcWrite_en); end
        n_tests++; if (if0.stallCount !== st_before + 32'd4) begin n_fail++; $display("FAIL mw_count got=%0d exp=%0d", if0.stallCount, st_before + 32'd4); end
        advance();
        nops(2);
    endtask

    task automatic test_reset_mid_stall();
        set_dec(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0);
        advance();
        set_dec(5'd0, 5'd5, 1'b0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        settle();
        n_tests++; if (if0.decodeBubble !== 1'b1) begin n_fail++; $display("FAIL rms_pre bub=%b exp=1", if0.decodeBubble); end
        reset = 1'b0;
        model_clear();
        settle();
        n_tests++; if (if0.forwardingSelWr !== 2'd0 || if0.pcWrite_en !== 1'b1 || if0.decodeBubble !== 1'b0) begin n_fail++; $display("FAIL rms_ctrl selWr=%0d pc=%b bub=%b exp=0/1/0", if0.forwardingSelWr, if0.pcWrite_en, if0.decodeBubble); end
        n_tests++; if (if0.stallCount !== 32'd0 || if0.flushCount !== 32'd0) begin n_fail++; $display("FAIL rms_counts got=%0d/%0d exp=0/0", if0.stallCount, if0.flushCount); end
        advance();
        reset = 1'b1;
        nops(1);
    endtask

    task automatic test_saturation();
        set_dec(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 20; i++) advance();
        settle();
        n_tests++; if (if1.stallCount !== 4'hF) begin n_fail++; $display("FAIL sat_4b got=%0d exp=15", if1.stallCount); end
        n_tests++; if (if0.stallCount !== m_st0) begin n_fail++; $display("FAIL sat_32b got=%0d exp=%0d", if0.stallCount, m_st0); end
        advance();
        settle();
        n_tests++; if (if1.stallCount !== 4'hF) begin n_fail++; $display("FAIL sat_hold got=%0d exp=15", if1.stallCount); end
        nops(2);
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            set_dec(regs[$urandom_range(0, 3)], regs[$urandom_range(0, 3)], 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), regs[$urandom_range(0, 3)],
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
                    ($urandom_range(0, 5) == 0));
            settle();
            n_tests++; if (if0.forwardingSelA !== e_a) begin n_fail++; $display("FAIL rnd_selA c=%0d got=%0d exp=%0d", c, if0.forwardingSelA, e_a); end
            n_tests++; if (if0.forwardingSelB !== e_b) begin n_fail++; $display("FAIL rnd_selB c=%0d got=%0d exp=%0d", c, if0.forwardingSelB, e_b); end
            n_tests++; if (if0.forwardingSelWr !== e_w) begin n_fail++; $display("FAIL rnd_selWr c=%0d got=%0d exp=%0d", c, if0.forwardingSelWr, e_w); end
            n_tests++; if (if0.pcWrite_en !== e_pc || if0.fetchRegWrite_en !== e_pc) begin n_fail++; $display("FAIL rnd_enables c=%0d got=%b%b exp=%b", c, if0.pcWrite_en, if0.fetchRegWrite_en, e_pc); end
            n_tests++; if (if0.decodeBubble !== e_bub) begin n_fail++; $display("FAIL rnd_bubble c=%0d got=%b exp=%b", c, if0.decodeBubble, e_bub); end
            n_tests++; if (if0.pipeFreeze !== e_frz) begin n_fail++; $display("FAIL rnd_freeze c=%0d got=%b exp=%b", c, if0.pipeFreeze, e_frz); end
            n_tests++; if (if0.flushFetch !== e_fl0 || if1.flushFetch !== 1'b0) begin n_fail++; $display("FAIL rnd_flush c=%0d got=%b/%b exp=%b/0", c, if0.flushFetch, if1.flushFetch, e_fl0); end
            n_tests++; if (if0.stallCount !== m_st0 || if1.stallCount !== m_st1) begin n_fail++; $display("FAIL rnd_stallcnt c=%0d got=%0d/%0d exp=%0d/%0d", c, if0.stallCount, if1.stallCount, m_st0, m_st1); end
            n_tests++; if (if0.flushCount !== m_fl0) begin n_fail++; $display("FAIL rnd_flushcnt c=%0d got=%0d exp=%0d", c, if0.flushCount, m_fl0); end
            n_tests++; if (if1.pcWrite_en !== e_pc || if1.forwardingSelA !== e_a) begin n_fail++; $display("FAIL rnd_dut1 c=%0d pc=%b selA=%0d exp=%b/%0d", c, if1.pcWrite_en, if1.forwardingSelA, e_pc, e_a); end
            advance();
        end
    endtask

    initial begin
        regs[0] = 5'd1; regs[1] = 5'd2; regs[2] = 5'd3; regs[3] = 5'd31;
        test_reset();
        test_alu_forward();
        test_load_use();
        test_cbz_flush();
        test_xzr();
        test_mem_wait();
        test_reset_mid_stall();
        test_saturation();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/hazard_forward_controller.md
Name: hazard_forward_controller

Overview:
Pipeline hazard and forwarding controller for the 5-stage ARM pipeline; sits beside the decode stage and drives its three forwarding-mux selects (operand A, operand B, store/CBZ data).
Keeps its own EX/MEM shadow of destination-register state and inserts load-use bubbles.
Freezes the whole pipeline while data memory is busy, and flushes the fetch register on taken branches when the delay slot is disabled.
Exposes saturating stall and flush counters.

Parameters:
BR_DELAY_SLOT, 1, 1 = instruction after a taken branch executes (no flush); 0 = flush fetch register on taken branch.
CNT_W, 32, width of performance counters.

Ports:
clk  input  1  pipeline clock
reset  input  1  asynchronous reset, active-low (asserted when 0)
Rn_Decode  input  5  source register 1 of instruction in decode
Src2_Decode  input  5  register presented to ReadRegister2 (Rm or Rd after Reg2Loc)
useRn_Decode  input  1  decode instruction reads Rn
useSrc2_Decode  input  1  decode instruction reads Src2 as ALU operand B
useWr_Decode  input  1  decode instruction reads Src2 as store data or CBZ operand
Rd_Decode  input  5  destination of decode instruction
RegWrite_Decode  input  1  decode instruction writes a register
MemToReg_Decode  input  1  decode instruction is a load
BrTaken_Decode  input  1  accelerated branch taken in decode
memBusy  input  1  data memory not ready this cycle
forwardingSelA  output  2  0 regfile, 1 ALUResult_EX, 2 resultForward_MEM
forwardingSelB  output  2  same encoding, operand B
forwardingSelWr  output  2  same encoding, store/CBZ data
pcWrite_en  output  1  PC register update enable
fetchRegWrite_en  output  1  fetch/decode pipeline register enable
decodeBubble  output  1  load zero controls into decode/EX register
pipeFreeze  output  1  hold EX/MEM, MEM/WB registers
flushFetch  output  1  load NOP into fetch/decode register
stallCount  output  CNT_W  cycles spent in LOAD_STALL or MEM_WAIT, saturating
flushCount  output  CNT_W  fetch flushes issued, saturating

Behaviour:
- Shadow regs: ex_{Rd,RegWrite,MemToReg}, mem_{Rd,RegWrite,MemToReg}.
- Reset clears the shadow regs, the counters and the state (state = RUN).
- Outputs while in reset: sels 0, pcWrite_en 1, fetchRegWrite_en 1, decodeBubble 0, pipeFreeze 0, flushFetch 0.
- Match rule, per source s:
  - exHit = ex_RegWrite & ex_Rd==s & s!=31.
  - memHit = mem_RegWrite & mem_Rd==s & s!=31.
  - X31 (XZR) never forwards and never stalls.
- Select rule: sel = 1 if exHit & !ex_MemToReg; else 2 if memHit; else 0.
  - An EX hit overrides a MEM hit.
  - If the matching use flag is 0, sel = 0.
  - SelB and SelWr both compare against Src2_Decode, gated by their own use flags.
- loadUse = any used source (Rn, Src2B, Src2Wr) with exHit & ex_MemToReg.
- FSM states: RUN, LOAD_STALL, MEM_WAIT. Next-state is evaluated every cycle with priority memBusy > loadUse.
  - memBusy=1 from any state -> MEM_WAIT.
  - In MEM_WAIT: pipeFreeze=1, pcWrite_en=0, fetchRegWrite_en=0, decodeBubble=0; shadow regs hold.
  - memBusy=0 in MEM_WAIT -> re-evaluate the next state as from RUN.
  - loadUse (and !memBusy) -> LOAD_STALL for exactly one cycle: pcWrite_en=0, fetchRegWrite_en=0, decodeBubble=1.
    - Shadow update on that edge: ex <= 0 (bubble), mem <= ex.
    - Next cycle the load is in MEM, the select becomes 2 and the FSM returns to RUN.
  - RUN shadow update: ex <= decode fields; mem <= ex.
- Outputs are combinational from state, shadow regs and decode inputs (Moore+Mealy). There is no added latency on sels.
- Branch flush: flushFetch = !BR_DELAY_SLOT & BrTaken_Decode & !loadUse & !memBusy.
  - A branch evaluated under a stall is ignored because the PC is held; it is re-evaluated next cycle with forwarded data.
- Counters:
  - stallCount += 1 each cycle with (loadUse | memBusy) asserted.
  - flushCount += 1 per flushFetch cycle.
  - Both saturate at all-ones; no wrap.
- Asynchronous reset mid-stall returns to RUN immediately and clears the counters.

Decomposition:
- Shared package hazard_pkg holds:
  - fwd_sel_t enum (FWD_REG=0, FWD_EX=1, FWD_MEM=2);
  - hz_state_t (RUN, LOAD_STALL, MEM_WAIT);
  - XZR constant 5'd31.
- One sub-module, fwd_compare: given source, use flag and EX/MEM shadow, returns the sel and the loadUse bit. It is instantiated three times (A, B, Wr).

Test Plan:
- ADDI X1 in EX, ADD X2,X1,X3 in decode -> forwardingSelA=1, no stall; one cycle later X1 in MEM, SelA=2 if a reader is in decode.
- LDUR X5 in EX, SUB using X5 as Rm -> one cycle pcWrite_en=0, decodeBubble=1, stallCount 0->1; next cycle SelB=2, state RUN.
- LDUR X5 then CBZ X5 -> SelWr=2 after a one-cycle stall; BrTaken with BR_DELAY_SLOT=0 raises flushFetch only after the stall; flushCount=1.
- Writer to X31 in EX, reader of X31 -> all sels 0, no stall.
- memBusy high 3 cycles during a load-use -> MEM_WAIT 3 cycles with pipeFreeze=1, then LOAD_STALL 1 cycle; stallCount=4.
- reset driven low mid LOAD_STALL -> immediate RUN, sels 0, counters 0; force stallCount to all-ones plus a stall -> stays all-ones.
